// File: rtl/decode_stage.sv
// RV32I/RV64I instruction decode stage: raw instruction + PC in, registered control bundle out.
// Latency 1 cycle; in_ready = !out_valid || out_ready, flush kills the bundle. Optional DECODE_STR_EN adds decode_str.
module decode_stage #(
    parameter int              XLEN       = 32,
    parameter int              ALU_CTRL_W = 4,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [XLEN-1:0]       in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic [XLEN-1:0]       imm,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  alu_src,
    output logic                  alu_pc,
    output logic [4:0]            rd,
    output logic [4:0]            rs1,
    output logic [4:0]            rs2,
    output logic                  reg_write,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [2:0]            mem_size,
    output logic                  branch,
    output logic                  jump,
`ifdef DECODE_STR_EN
    output logic [79:0]           decode_str,
`endif
    output logic                  illegal
);

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD   = ALU_CTRL_W'(4'h0);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB   = ALU_CTRL_W'(4'h1);
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR   = ALU_CTRL_W'(4'h2);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR    = ALU_CTRL_W'(4'h3);
    localparam logic [ALU_CTRL_W-1:0] ALU_AND   = ALU_CTRL_W'(4'h4);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL   = ALU_CTRL_W'(4'h5);
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL   = ALU_CTRL_W'(4'h6);
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA   = ALU_CTRL_W'(4'h7);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT   = ALU_CTRL_W'(4'h8);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU  = ALU_CTRL_W'(4'h9);
    localparam logic [ALU_CTRL_W-1:0] ALU_PASSB = ALU_CTRL_W'(4'hA);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];
    assign imm_i  = {{(XLEN-11){in_instr[31]}}, in_instr[30:20]};
    assign imm_s  = {{(XLEN-11){in_instr[31]}}, in_instr[30:25], in_instr[11:7]};
    assign imm_b  = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_j  = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    assign imm_u  = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};

    logic [XLEN-1:0]       imm_d;
    logic [ALU_CTRL_W-1:0] alu_d;
    logic                  src_d, apc_d, wr_d, mr_d, mw_d, br_d, jmp_d, ill_d;
    logic [2:0]            msz_d;

    always_comb begin
        imm_d = '0;
        alu_d = ALU_ADD;
        src_d = 1'b0;
        apc_d = 1'b0;
        wr_d  = 1'b0;
        mr_d  = 1'b0;
        mw_d  = 1'b0;
        msz_d = 3'd0;
        br_d  = 1'b0;
        jmp_d = 1'b0;
        ill_d = 1'b0;
        case (opcode)
            OP_R: begin
                wr_d = 1'b1;
                if (f7 == 7'h00) begin
                    case (f3)
                        3'd0:    alu_d = ALU_ADD;
                        3'd1:    alu_d = ALU_SLL;
                        3'd2:    alu_d = ALU_SLT;
                        3'd3:    alu_d = ALU_SLTU;
                        3'd4:    alu_d = ALU_XOR;
                        3'd5:    alu_d = ALU_SRL;
                        3'd6:    alu_d = ALU_OR;
                        default: alu_d = ALU_AND;
                    endcase
                end else if (f7 == 7'h20 && f3 == 3'd0) begin
                    alu_d = ALU_SUB;
                end else if (f7 == 7'h20 && f3 == 3'd5) begin
                    alu_d = ALU_SRA;
                end else begin
                    ill_d = 1'b1;
                end
            end
            OP_IMM: begin
                src_d = 1'b1;
                wr_d  = 1'b1;
                imm_d = imm_i;
                case (f3)
                    3'd0:    alu_d = ALU_ADD;
                    3'd1:    alu_d = ALU_SLL;
                    3'd2:    alu_d = ALU_SLT;
                    3'd3:    alu_d = ALU_SLTU;
                    3'd4:    alu_d = ALU_XOR;
                    3'd5:    alu_d = in_instr[30] ? ALU_SRA : ALU_SRL;
                    3'd6:    alu_d = ALU_OR;
                    default: alu_d = ALU_AND;
                endcase
                if ((f3 == 3'd1 || f3 == 3'd5) && f7 != 7'h00 && f7 != 7'h20)
                    ill_d = 1'b1;
            end
            OP_LOAD: begin
                src_d = 1'b1;
                wr_d  = 1'b1;
                mr_d  = 1'b1;
                msz_d = f3;
                imm_d = imm_i;
                ill_d = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            end
            OP_STORE: begin
                src_d = 1'b1;
                mw_d  = 1'b1;
                msz_d = f3;
                imm_d = imm_s;
                ill_d = (f3 > 3'd2);
            end
            OP_BRANCH: begin
                br_d  = 1'b1;
                imm_d = imm_b;
                case (f3)
                    3'd0, 3'd1: alu_d = ALU_SUB;
                    3'd4, 3'd5: alu_d = ALU_SLT;
                    3'd6, 3'd7: alu_d = ALU_SLTU;
                    default:    ill_d = 1'b1;
                endcase
            end
            OP_JAL: begin
                apc_d = 1'b1;
                src_d = 1'b1;
                jmp_d = 1'b1;
                wr_d  = 1'b1;
                imm_d = imm_j;
            end
            OP_JALR: begin
                src_d = 1'b1;
                jmp_d = 1'b1;
                wr_d  = 1'b1;
                imm_d = imm_i;
                ill_d = (f3 != 3'd0);
            end
            OP_LUI: begin
                alu_d = ALU_PASSB;
                src_d = 1'b1;
                wr_d  = 1'b1;
                imm_d = imm_u;
            end
            OP_AUIPC: begin
                apc_d = 1'b1;
                src_d = 1'b1;
                wr_d  = 1'b1;
                imm_d = imm_u;
            end
            default: ill_d = 1'b1;
        endcase
        // An illegal bundle still flows downstream but must have no side effects.
        if (ill_d) begin
            wr_d  = 1'b0;
            mr_d  = 1'b0;
            mw_d  = 1'b0;
            br_d  = 1'b0;
            jmp_d = 1'b0;
        end
        if (in_instr[11:7] == 5'd0)
            wr_d = 1'b0;
    end

`ifdef DECODE_STR_EN
    logic [79:0] str_d, str_q;

    always_comb begin
        str_d = "UNKNOWN";
        if (!ill_d) begin
            case (opcode)
                OP_R: begin
                    case (f3)
                        3'd0:    str_d = in_instr[30] ? "SUB" : "ADD";
                        3'd1:    str_d = "SLL";
                        3'd2:    str_d = "SLT";
                        3'd3:    str_d = "SLTU";
                        3'd4:    str_d = "XOR";
                        3'd5:    str_d = in_instr[30] ? "SRA" : "SRL";
                        3'd6:    str_d = "OR";
                        default: str_d = "AND";
                    endcase
                end
                OP_IMM: begin
                    case (f3)
                        3'd0:    str_d = "ADDI";
                        3'd1:    str_d = "SLLI";
                        3'd2:    str_d = "SLTI";
                        3'd3:    str_d = "SLTIU";
                        3'd4:    str_d = "XORI";
                        3'd5:    str_d = in_instr[30] ? "SRAI" : "SRLI";
                        3'd6:    str_d = "ORI";
                        default: str_d = "ANDI";
                    endcase
                end
                OP_LOAD: begin
                    case (f3)
                        3'd0:    str_d = "LB";
                        3'd1:    str_d = "LH";
                        3'd2:    str_d = "LW";
                        3'd4:    str_d = "LBU";
                        default: str_d = "LHU";
                    endcase
                end
                OP_STORE: begin
                    case (f3)
                        3'd0:    str_d = "SB";
                        3'd1:    str_d = "SH";
                        default: str_d = "SW";
                    endcase
                end
                OP_BRANCH: begin
                    case (f3)
                        3'd0:    str_d = "BEQ";
                        3'd1:    str_d = "BNE";
                        3'd4:    str_d = "BLT";
                        3'd5:    str_d = "BGE";
                        3'd6:    str_d = "BLTU";
                        default: str_d = "BGEU";
                    endcase
                end
                OP_JAL:   str_d = "JAL";
                OP_JALR:  str_d = "JALR";
                OP_LUI:   str_d = "LUI";
                OP_AUIPC: str_d = "AUIPC";
                default:  str_d = "UNKNOWN";
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            str_q <= "RESET";
        else if (!flush && in_valid && in_ready)
            str_q <= str_d;
    end

    assign decode_str = str_q;
`endif

    logic                  rdy_q, vld_q;
    logic [XLEN-1:0]       pc_q, imm_q;
    logic [ALU_CTRL_W-1:0] alu_q;
    logic                  src_q, apc_q, wr_q, mr_q, mw_q, br_q, jmp_q, ill_q;
    logic [2:0]            msz_q;
    logic [4:0]            rd_q, rs1_q, rs2_q;

    // rdy_q keeps in_ready low while reset is held and for the release edge.
    assign in_ready = rdy_q && (!vld_q || out_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_q <= 1'b0;
            vld_q <= 1'b0;
            pc_q  <= RESET_PC;
            imm_q <= '0;
            alu_q <= '0;
            src_q <= 1'b0;
            apc_q <= 1'b0;
            wr_q  <= 1'b0;
            mr_q  <= 1'b0;
            mw_q  <= 1'b0;
            msz_q <= 3'd0;
            br_q  <= 1'b0;
            jmp_q <= 1'b0;
            ill_q <= 1'b0;
            rd_q  <= 5'd0;
            rs1_q <= 5'd0;
            rs2_q <= 5'd0;
        end else begin
            rdy_q <= 1'b1;
            if (flush) begin
                vld_q <= 1'b0;
                wr_q  <= 1'b0;
                mr_q  <= 1'b0;
                mw_q  <= 1'b0;
                br_q  <= 1'b0;
                jmp_q <= 1'b0;
                ill_q <= 1'b0;
            end else if (in_valid && in_ready) begin
                vld_q <= 1'b1;
                pc_q  <= in_pc;
                imm_q <= imm_d;
                alu_q <= alu_d;
                src_q <= src_d;
                apc_q <= apc_d;
                wr_q  <= wr_d;
                mr_q  <= mr_d;
                mw_q  <= mw_d;
                msz_q <= msz_d;
                br_q  <= br_d;
                jmp_q <= jmp_d;
                ill_q <= ill_d;
                rd_q  <= in_instr[11:7];
                rs1_q <= in_instr[19:15];
                rs2_q <= in_instr[24:20];
            end else if (out_ready) begin
                vld_q <= 1'b0;
            end
        end
    end

    assign out_valid = vld_q;
    assign out_pc    = pc_q;
    assign imm       = imm_q;
    assign alu_ctrl  = alu_q;
    assign alu_src   = src_q;
    assign alu_pc    = apc_q;
    assign rd        = rd_q;
    assign rs1       = rs1_q;
    assign rs2       = rs2_q;
    assign reg_write = wr_q;
    assign mem_read  = mr_q;
    assign mem_write = mw_q;
    assign mem_size  = msz_q;
    assign branch    = br_q;
    assign jump      = jmp_q;
    assign illegal   = ill_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: back-to-back vector table through a scoreboard queue, then stall/drop/flush/reset sequences.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, imm;
    logic [3:0]  alu_ctrl;
    logic        alu_src, alu_pc, reg_write, mem_read, mem_write, branch, jump, illegal;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  mem_size;
`ifdef DECODE_STR_EN
    logic [79:0] decode_str;
`endif

    decode_stage #(.XLEN(32), .ALU_CTRL_W(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .imm(imm),
        .alu_ctrl(alu_ctrl), .alu_src(alu_src), .alu_pc(alu_pc),
        .rd(rd), .rs1(rs1), .rs2(rs2), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .branch(branch), .jump(jump),
`ifdef DECODE_STR_EN
        .decode_str(decode_str),
`endif
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    // full=0 rows are illegal encodings: only the side-effect controls are defined.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        src, apc, rw, mr, mw;
        logic [2:0]  msz;
        logic        br, jmp, ill, full;
        logic [31:0] pc;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];
    vec_t sb_q [$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cur(input vec_t v);
        vec_t e;
        e = v;
        e.pc = in_pc;
        sb_q.push_back(e);
    endtask

    task automatic check_out();
        vec_t e;
        chk("out_valid", out_valid, 1);
        if (sb_q.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            chk("illegal", illegal, e.ill);
            chk("reg_write", reg_write, e.rw);
            chk("mem_read", mem_read, e.mr);
            chk("mem_write", mem_write, e.mw);
            chk("branch", branch, e.br);
            chk("jump", jump, e.jmp);
            chk("out_pc", out_pc, e.pc);
            if (e.full) begin
                chk("imm", imm, e.imm);
                chk("alu_ctrl", alu_ctrl, e.alu);
                chk("alu_src", alu_src, e.src);
                chk("alu_pc", alu_pc, e.apc);
                chk("mem_size", mem_size, e.msz);
                chk("rd", rd, e.instr[11:7]);
                chk("rs1", rs1, e.instr[19:15]);
                chk("rs2", rs2, e.instr[24:20]);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t sw_v, add_v, lw_v;
        //            instr         imm           alu   src   apc   rw    mr    mw    msz   br    jmp   ill   full  pc
        vecs[0]  = '{32'h002081B3, 32'h00000000, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[1]  = '{32'hFFF00093, 32'hFFFFFFFF, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[2]  = '{32'h402081B3, 32'h00000000, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[3]  = '{32'h0020A423, 32'h00000008, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[4]  = '{32'hFE000EE3, 32'hFFFFFFFC, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[5]  = '{32'h123452B7, 32'h12345000, 4'hA, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[6]  = '{32'h0000707F, 32'h00000000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[7]  = '{32'h00003003, 32'h00000000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[8]  = '{32'hFFC12283, 32'hFFFFFFFC, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[9]  = '{32'h008000EF, 32'h00000008, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0};
        vecs[10] = '{32'h00008067, 32'h00000000, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0};
        vecs[11] = '{32'h80000397, 32'h80000000, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[12] = '{32'h40325213, 32'h00000403, 4'h7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[13] = '{32'h20101093, 32'h00000000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[14] = '{32'h4020C1B3, 32'h00000000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[15] = '{32'h0020E863, 32'h00000010, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[16] = '{32'h00002063, 32'h00000000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[17] = '{32'h0020C1B3, 32'h00000000, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[18] = '{32'h00513093, 32'h00000005, 4'h9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[19] = '{32'h00208033, 32'h00000000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
        sw_v  = vecs[3];
        add_v = vecs[0];
        lw_v  = vecs[8];

        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_imm", imm, 0);
        chk("rst_reg_write", reg_write, 0);
        chk("rst_illegal", illegal, 0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        tick();
        chk("in_ready_after_release", in_ready, 1);

        // Back-to-back: one instruction accepted every cycle with out_ready held high.
        for (int i = 0; i < NV; i++) begin
            in_instr = vecs[i].instr;
            in_pc    = 32'h1000 + 32'(i * 4);
            in_valid = 1'b1;
            #1;
            chk("in_ready_stream", in_ready, 1);
            if (in_ready) push_cur(vecs[i]);
            tick();
            check_out();
        end

        in_valid = 1'b0;
        tick();
        chk("drop_out_valid", out_valid, 0);
        chk("drop_imm_held", imm, vecs[NV-1].imm);
        chk("drop_pc_held", out_pc, 32'h1000 + 32'((NV - 1) * 4));

        // Stall: SW is held while a waiting ADD is refused.
        in_instr = sw_v.instr; in_pc = 32'h2000; in_valid = 1'b1;
        #1;
        push_cur(sw_v);
        tick();
        check_out();
        out_ready = 1'b0;
        in_instr = add_v.instr; in_pc = 32'h2004;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_in_ready", in_ready, 0);
            tick();
            chk("stall_out_valid", out_valid, 1);
            chk("stall_imm", imm, 32'h8);
            chk("stall_mem_write", mem_write, 1);
            chk("stall_mem_size", mem_size, 2);
            chk("stall_pc", out_pc, 32'h2000);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", in_ready, 1);
        if (in_ready) push_cur(add_v);
        tick();
        check_out();

        // Flush alongside an incoming instruction while a bundle is valid.
        in_instr = lw_v.instr; in_pc = 32'h3000;
        #1;
        push_cur(lw_v);
        tick();
        check_out();
        flush = 1'b1; in_instr = add_v.instr; in_pc = 32'h3004;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_reg_write", reg_write, 0);
        chk("flush_mem_read", mem_read, 0);
        tick();
        chk("flush_never_appears", out_valid, 0);
        chk("flush_sb_empty", sb_q.size(), 0);

        // Asynchronous reset in the middle of a stall.
        out_ready = 1'b0;
        in_instr = sw_v.instr; in_pc = 32'h4000; in_valid = 1'b1;
        #1;
        push_cur(sw_v);
        tick();
        check_out();
        in_valid = 1'b0;
        tick();
        chk("pre_reset_stalled", out_valid, 1);
        #2 reset = 1'b0;
        #1;
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_mem_write", mem_write, 0);
        chk("midreset_out_pc", out_pc, 0);
        chk("midreset_in_ready", in_ready, 0);
        #3 reset = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        chk("post_reset_in_ready", in_ready, 1);
        chk("post_reset_out_valid", out_valid, 0);
        chk("final_sb_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
